// File: rtl/bullet_scheduler_pkg.sv
// Shared types and constants for the bullet pool scheduler.
package bullet_pkg;

    localparam int unsigned NUM_PLAYERS = 2;
    localparam int unsigned COORD_W     = 10;
    localparam int unsigned DIR_W       = 2;
    localparam int unsigned LIVE_W      = 3;
    localparam int unsigned SHOT_W      = 16;
    localparam int unsigned DROP_W      = 8;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_UP    = 2'b10
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        SETTLE = 2'd2
    } sched_state_t;

    // Facing code 11 has no bullet direction of its own; it fires right.
    function automatic dir_t norm_dir(input logic [DIR_W-1:0] raw);
        return (raw == 2'b11) ? DIR_RIGHT : dir_t'(raw);
    endfunction

endpackage

// File: rtl/bullet_scheduler_if.sv
// Scheduler <-> bullet-instance bus: busy flags in, launch pulse and start data out.
interface bullet_scheduler_if
    import bullet_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 4
);
    logic [NUM_SLOTS-1:0] slot_busy;
    logic [NUM_SLOTS-1:0] launch;
    logic [COORD_W-1:0]   start_x;
    logic [COORD_W-1:0]   start_y;
    logic [DIR_W-1:0]     launch_dir;

    modport master (input slot_busy, output launch, start_x, start_y, launch_dir);
    modport slave  (output slot_busy, input launch, start_x, start_y, launch_dir);
endinterface

// File: rtl/bullet_scheduler_slot_pick.sv
// Lowest-index free-slot finder over the busy flags and the reservation mask.
module bullet_slot_pick #(
    parameter int unsigned NUM_SLOTS = 4
) (
    input  logic [NUM_SLOTS-1:0] slot_busy,
    input  logic [NUM_SLOTS-1:0] reserved,
    output logic                 found_c,
    output logic [NUM_SLOTS-1:0] slot_oh_c
);
    logic [NUM_SLOTS-1:0] free_c;

    assign free_c    = ~slot_busy & ~reserved;
    assign found_c   = |free_c;
    // Isolate the lowest set bit: x & -x.
    assign slot_oh_c = free_c & (~free_c + NUM_SLOTS'(1));
endmodule

// File: rtl/bullet_scheduler.sv
// Bullet pool scheduler: fire-edge detect, cooldown/quota gating, round-robin grant and
// one-cycle launch into the lowest free slot. Optional counters under BULLET_SCHED_STATS_EN.
module bullet_scheduler
    import bullet_pkg::*;
#(
    parameter int unsigned NUM_SLOTS       = 4,
    parameter int unsigned MAX_PER_PLAYER  = 2,
    parameter int unsigned COOLDOWN_FRAMES = 15,
    parameter int unsigned CD_W            = 5
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   frame_clk,
    input  logic [NUM_PLAYERS-1:0] fire_btn,
    input  logic [COORD_W-1:0]     tank0_x,
    input  logic [COORD_W-1:0]     tank0_y,
    input  logic [COORD_W-1:0]     tank1_x,
    input  logic [COORD_W-1:0]     tank1_y,
    input  logic [DIR_W-1:0]       tank0_dir,
    input  logic [DIR_W-1:0]       tank1_dir,
    bullet_scheduler_if.master     bus,
    output logic                   grant_player,
    output logic                   sched_busy,
    output logic [LIVE_W-1:0]      live_count0,
    output logic [LIVE_W-1:0]      live_count1
`ifdef BULLET_SCHED_STATS_EN
    ,
    output logic [SHOT_W-1:0]      shots0,
    output logic [SHOT_W-1:0]      shots1,
    output logic [DROP_W-1:0]      dropped0,
    output logic [DROP_W-1:0]      dropped1
`endif
);
    sched_state_t           state_q, state_d;
    logic [NUM_PLAYERS-1:0] fire_q, fire_q2, fire_rise_c, pending_q, elig_c;
    logic [2:0]             frame_sync_q;
    logic                   frame_rise_c;
    logic [CD_W-1:0]        cooldown_q [NUM_PLAYERS];
    logic [NUM_SLOTS-1:0]   owner_q, owned_q, reserved_q, launch_q, pick_oh_c;
    logic                   pick_found_c;
    logic                   win_c, win_q, prio_q;
    logic                   latch_c, fire_c, release_c;
    logic [COORD_W-1:0]     start_x_q, start_y_q;
    dir_t                   dir_q;

    assign fire_rise_c  = fire_q & ~fire_q2;
    assign frame_rise_c = frame_sync_q[1] & ~frame_sync_q[2];

    assign bus.launch     = launch_q;
    assign bus.start_x    = start_x_q;
    assign bus.start_y    = start_y_q;
    assign bus.launch_dir = DIR_W'(dir_q);

    bullet_slot_pick #(.NUM_SLOTS(NUM_SLOTS)) u_pick (
        .slot_busy (bus.slot_busy),
        .reserved  (reserved_q),
        .found_c   (pick_found_c),
        .slot_oh_c (pick_oh_c)
    );

    // Live bullets per player: busy slots whose last launch belonged to that player.
    always_comb begin
        live_count0 = '0;
        live_count1 = '0;
        for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            if (bus.slot_busy[s] && owned_q[s]) begin
                if (owner_q[s]) live_count1 = live_count1 + LIVE_W'(1);
                else            live_count0 = live_count0 + LIVE_W'(1);
            end
        end
    end

    assign elig_c[0] = pending_q[0] && (32'(live_count0) < MAX_PER_PLAYER) && pick_found_c;
    assign elig_c[1] = pending_q[1] && (32'(live_count1) < MAX_PER_PLAYER) && pick_found_c;
    assign win_c     = (&elig_c) ? prio_q : elig_c[1];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|elig_c) state_d = LAUNCH;
            LAUNCH:  state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        latch_c   = 1'b0;
        fire_c    = 1'b0;
        release_c = 1'b0;
        case (state_q)
            IDLE:    latch_c   = |elig_c;
            LAUNCH:  fire_c    = 1'b1;
            SETTLE:  release_c = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fire_q       <= '0;
            fire_q2      <= '0;
            frame_sync_q <= '0;
            pending_q    <= '0;
            owner_q      <= '0;
            owned_q      <= '0;
            reserved_q   <= '0;
            launch_q     <= '0;
            win_q        <= 1'b0;
            prio_q       <= 1'b0;
            grant_player <= 1'b0;
            sched_busy   <= 1'b0;
            start_x_q    <= '0;
            start_y_q    <= '0;
            dir_q        <= DIR_LEFT;
            for (int p = 0; p < NUM_PLAYERS; p++) cooldown_q[p] <= '0;
        end else begin
            fire_q       <= fire_btn;
            fire_q2      <= fire_q;
            frame_sync_q <= {frame_sync_q[1:0], frame_clk};
            sched_busy   <= (state_d != IDLE);
            launch_q     <= '0;
            if (latch_c) begin
                win_q        <= win_c;
                prio_q       <= ~win_c;
                grant_player <= win_c;
                reserved_q   <= pick_oh_c;
                launch_q     <= pick_oh_c;
                start_x_q    <= win_c ? tank1_x : tank0_x;
                start_y_q    <= win_c ? tank1_y : tank0_y;
                dir_q        <= norm_dir(win_c ? tank1_dir : tank0_dir);
                for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
                    if (pick_oh_c[s]) begin
                        owner_q[s] <= win_c;
                        owned_q[s] <= 1'b1;
                    end
                end
            end
            if (release_c) reserved_q <= '0;
            // Granting a shot wins over a coincident press or frame tick.
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (fire_c && (win_q == 1'(p))) begin
                    pending_q[p]  <= 1'b0;
                    cooldown_q[p] <= CD_W'(COOLDOWN_FRAMES);
                end else begin
                    if (fire_rise_c[p] && (cooldown_q[p] == '0)) pending_q[p] <= 1'b1;
                    if (frame_rise_c && (cooldown_q[p] != '0))
                        cooldown_q[p] <= cooldown_q[p] - CD_W'(1);
                end
            end
        end
    end

`ifdef BULLET_SCHED_STATS_EN
    logic [SHOT_W-1:0] shots_q [NUM_PLAYERS];
    logic [DROP_W-1:0] drop_q  [NUM_PLAYERS];

    // Shots wrap; dropped presses saturate.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                shots_q[p] <= '0;
                drop_q[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (fire_c && (win_q == 1'(p))) shots_q[p] <= shots_q[p] + SHOT_W'(1);
                if (fire_rise_c[p] && (cooldown_q[p] != '0) && (drop_q[p] != '1))
                    drop_q[p] <= drop_q[p] + DROP_W'(1);
            end
        end
    end

    assign shots0   = shots_q[0];
    assign shots1   = shots_q[1];
    assign dropped0 = drop_q[0];
    assign dropped1 = drop_q[1];
`endif

endmodule

// File: tb/tb_bullet_scheduler.sv
// Self-checking bench for bullet_scheduler: vector table, corner sequences, random run vs model.
module tb_bullet_scheduler;
    import bullet_pkg::*;

    localparam int unsigned NS   = 4;
    localparam int unsigned MAXP = 2;
    localparam int unsigned CDF  = 15;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b1;
    logic          frame_clk = 1'b0;
    logic [1:0]    fire_btn = '0;
    logic [9:0]    t0x = 10'd100, t0y = 10'd200, t1x = 10'd300, t1y = 10'd400;
    logic [1:0]    t0d = 2'b10, t1d = 2'b11;
    logic [NS-1:0] busy = '0;
    logic          grant_player, sched_busy;
    logic [2:0]    live_count0, live_count1;
`ifdef BULLET_SCHED_STATS_EN
    logic [15:0]   shots0, shots1;
    logic [7:0]    dropped0, dropped1;
`endif

    bullet_scheduler_if #(.NUM_SLOTS(NS)) bus ();
    assign bus.slot_busy = busy;

    bullet_scheduler #(.NUM_SLOTS(NS), .MAX_PER_PLAYER(MAXP), .COOLDOWN_FRAMES(CDF), .CD_W(5)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .fire_btn(fire_btn),
        .tank0_x(t0x), .tank0_y(t0y), .tank1_x(t1x), .tank1_y(t1y),
        .tank0_dir(t0d), .tank1_dir(t1d), .bus(bus),
        .grant_player(grant_player), .sched_busy(sched_busy),
        .live_count0(live_count0), .live_count1(live_count1)
`ifdef BULLET_SCHED_STATS_EN
        , .shots0(shots0), .shots1(shots1), .dropped0(dropped0), .dropped1(dropped1)
`endif
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit frame_run = 1'b0;
    int fcnt = 0;

    // Behavioural reference state
    bit [1:0]    m_fq, m_fq2;
    bit [2:0]    m_fs;
    bit [1:0]    m_pend;
    int          m_cd [2];
    bit [NS-1:0] m_owner, m_owned, m_res, m_launch;
    int          m_phase;
    bit          m_win, m_prio, m_gp;
    int          m_sx, m_sy, m_dir;
    int          m_shots [2];
    int          m_drop [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: actual %0h required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_fq = 0; m_fq2 = 0; m_fs = 0; m_pend = 0;
        m_owner = 0; m_owned = 0; m_res = 0; m_launch = 0;
        m_phase = 0; m_win = 0; m_prio = 0; m_gp = 0;
        m_sx = 0; m_sy = 0; m_dir = 0;
        for (int p = 0; p < 2; p++) begin
            m_cd[p] = 0; m_shots[p] = 0; m_drop[p] = 0;
        end
    endtask

    function automatic int mlive(input int p);
        int n = 0;
        for (int s = 0; s < NS; s++)
            if (busy[s] && m_owned[s] && (int'(m_owner[s]) == p)) n++;
        return n;
    endfunction

    // One clock of the reference, from the inputs present before the edge.
    task automatic model_advance();
        bit [1:0]    rise;
        bit          frise;
        bit [NS-1:0] freev;
        int          pick;
        bit [1:0]    el;
        bit          w;
        if (!Reset_n) begin
            model_reset();
            return;
        end
        rise  = m_fq & ~m_fq2;
        frise = m_fs[1] & ~m_fs[2];
        freev = ~busy & ~m_res;
        pick  = -1;
        for (int s = NS - 1; s >= 0; s--) if (freev[s]) pick = s;
        for (int p = 0; p < 2; p++) el[p] = m_pend[p] && (mlive(p) < MAXP) && (pick >= 0);
        w = (el == 2'b11) ? m_prio : el[1];
        for (int p = 0; p < 2; p++) begin
            if (m_phase == 1 && int'(m_win) == p) begin
                m_pend[p] = 0;
                m_cd[p] = CDF;
                m_shots[p] = (m_shots[p] + 1) % 65536;
            end else begin
                if (rise[p]) begin
                    if (m_cd[p] == 0) m_pend[p] = 1;
                    else if (m_drop[p] < 255) m_drop[p]++;
                end
                if (frise && m_cd[p] > 0) m_cd[p]--;
            end
        end
        m_launch = 0;
        case (m_phase)
            0: if (el != 0) begin
                m_phase = 1;
                m_win = w; m_gp = w; m_prio = !w;
                m_launch = NS'(1) << pick;
                m_res = m_launch;
                m_owner[pick] = w;
                m_owned[pick] = 1;
                m_sx  = w ? int'(t1x) : int'(t0x);
                m_sy  = w ? int'(t1y) : int'(t0y);
                m_dir = w ? int'(t1d) : int'(t0d);
                if (m_dir == 3) m_dir = 1;
            end
            1: m_phase = 2;
            default: begin m_phase = 0; m_res = 0; end
        endcase
        m_fq2 = m_fq; m_fq = fire_btn;
        m_fs = {m_fs[1:0], frame_clk};
    endtask

    task automatic compare_all();
        check("launch", 32'(bus.launch), 32'(m_launch));
        check("sched_busy", 32'(sched_busy), 32'(m_phase != 0));
        check("grant_player", 32'(grant_player), 32'(m_gp));
        check("live_count0", 32'(live_count0), 32'(mlive(0)));
        check("live_count1", 32'(live_count1), 32'(mlive(1)));
        if (m_launch != 0) begin
            check("start_x", 32'(bus.start_x), 32'(m_sx));
            check("start_y", 32'(bus.start_y), 32'(m_sy));
            check("launch_dir", 32'(bus.launch_dir), 32'(m_dir));
        end
    endtask

    // Advance one clock, compare, then let launched bullets come alive and tick the frame strobe.
    task automatic step();
        @(posedge Clk);
        model_advance();
        cyc++;
        #1;
        compare_all();
        busy = busy | bus.launch & m_launch;
        if (frame_run) begin
            fcnt++;
            if (fcnt % 4 == 0) frame_clk = ~frame_clk;
        end
    endtask

    task automatic do_reset();
        fire_btn = 0; busy = 0; frame_run = 0; frame_clk = 0; fcnt = 0;
        Reset_n = 0;
        model_reset();
        step();
        step();
        Reset_n = 1;
    endtask

    // Press, expect the launch two clocks after the press is registered, then release.
    task automatic press_expect(input logic [1:0] f, input logic [3:0] exp_l, input logic exp_g,
                                input string name);
        fire_btn = f;
        step(); step(); step();
        check(name, 32'(bus.launch), 32'(exp_l));
        if (exp_l != 0) check({name, "_gp"}, 32'(grant_player), 32'(exp_g));
        fire_btn = 0;
        step();
    endtask

    typedef struct {
        logic [1:0] fire;
        logic [3:0] busy;
        logic [3:0] exp_launch;
        logic       exp_gp;
        logic [9:0] exp_x;
        logic [9:0] exp_y;
        logic [1:0] exp_dir;
    } vec_t;

    vec_t vt [7];
    int   nl;
    bit   seen;

    initial begin
        vt[0] = '{2'b01, 4'b0000, 4'b0001, 1'b0, 10'd100, 10'd200, 2'b10};
        vt[1] = '{2'b10, 4'b0000, 4'b0001, 1'b1, 10'd300, 10'd400, 2'b01};
        vt[2] = '{2'b11, 4'b0000, 4'b0001, 1'b0, 10'd100, 10'd200, 2'b10};
        vt[3] = '{2'b01, 4'b0011, 4'b0100, 1'b0, 10'd100, 10'd200, 2'b10};
        vt[4] = '{2'b10, 4'b1011, 4'b0100, 1'b1, 10'd300, 10'd400, 2'b01};
        vt[5] = '{2'b01, 4'b1111, 4'b0000, 1'b0, 10'd0,   10'd0,   2'b00};
        vt[6] = '{2'b10, 4'b0110, 4'b0001, 1'b1, 10'd300, 10'd400, 2'b01};

        #1;
        do_reset();
        check("rst_launch", 32'(bus.launch), 32'd0);
        check("rst_sched_busy", 32'(sched_busy), 32'd0);
        check("rst_live0", 32'(live_count0), 32'd0);
        check("rst_grant", 32'(grant_player), 32'd0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            busy = vt[i].busy;
            fire_btn = vt[i].fire;
            step(); step(); step();
            check($sformatf("vec%0d_launch", i), 32'(bus.launch), 32'(vt[i].exp_launch));
            if (vt[i].exp_launch != 0) begin
                check($sformatf("vec%0d_gp", i), 32'(grant_player), 32'(vt[i].exp_gp));
                check($sformatf("vec%0d_x", i), 32'(bus.start_x), 32'(vt[i].exp_x));
                check($sformatf("vec%0d_y", i), 32'(bus.start_y), 32'(vt[i].exp_y));
                check($sformatf("vec%0d_dir", i), 32'(bus.launch_dir), 32'(vt[i].exp_dir));
            end
            fire_btn = 0;
            repeat (4) step();
        end

        // Cooldown drop, recovery, then quota block
        do_reset();
        frame_run = 1;
        press_expect(2'b01, 4'b0001, 1'b0, "cd_first");
        repeat (40) step();
        fire_btn = 2'b01;
        nl = 0;
        repeat (20) begin step(); if (bus.launch != 0) nl++; end
        check("cd_dropped_no_launch", 32'(nl), 32'd0);
        fire_btn = 0;
        repeat (130) step();
        press_expect(2'b01, 4'b0010, 1'b0, "cd_recovered");
        repeat (170) step();
        press_expect(2'b01, 4'b0000, 1'b0, "quota_block");
        repeat (10) step();
        busy[0] = 1'b0;
        seen = 0;
        repeat (2) begin step(); if (bus.launch == 4'b0001) seen = 1; end
        check("quota_release_launch", 32'(seen), 32'd1);

        // Simultaneous presses, pointer at P0 then at P1
        do_reset();
        press_expect(2'b11, 4'b0001, 1'b0, "tie0_first");
        step(); step();
        check("tie0_second", 32'(bus.launch), 32'b0010);
        check("tie0_second_gp", 32'(grant_player), 32'd1);
        do_reset();
        frame_run = 1;
        press_expect(2'b01, 4'b0001, 1'b0, "tie1_setup");
        repeat (150) step();
        press_expect(2'b11, 4'b0010, 1'b1, "tie1_first");
        step(); step();
        check("tie1_second", 32'(bus.launch), 32'b0100);
        check("tie1_second_gp", 32'(grant_player), 32'd0);

        // Pool full, P1 waits for slot2
        do_reset();
        busy = 4'b1111;
        press_expect(2'b10, 4'b0000, 1'b0, "full_no_launch");
        repeat (10) step();
        busy[2] = 1'b0;
        step();
        check("full_release_launch", 32'(bus.launch), 32'b0100);
        check("full_release_gp", 32'(grant_player), 32'd1);

        // Asynchronous reset while launching
        do_reset();
        fire_btn = 2'b01;
        step(); step(); step();
        check("mid_launch_pre", 32'(bus.launch), 32'b0001);
        #2;
        Reset_n = 0;
        fire_btn = 0;
        #1;
        model_reset();
        check("async_rst_launch", 32'(bus.launch), 32'd0);
        check("async_rst_busy", 32'(sched_busy), 32'd0);
        check("async_rst_live0", 32'(live_count0), 32'd0);
        check("async_rst_live1", 32'(live_count1), 32'd0);
        step();
        Reset_n = 1;
        nl = 0;
        repeat (10) begin step(); if (bus.launch != 0) nl++; end
        check("async_rst_no_pending", 32'(nl), 32'd0);

        // Random traffic against the reference
        do_reset();
        frame_run = 1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) fire_btn = 2'($urandom);
            if ($urandom_range(0, 9) == 0) busy[$urandom_range(0, NS - 1)] = 1'b0;
            if ($urandom_range(0, 31) == 0) begin
                t0x = 10'($urandom); t0y = 10'($urandom); t0d = 2'($urandom);
                t1x = 10'($urandom); t1y = 10'($urandom); t1d = 2'($urandom);
            end
            step();
        end
`ifdef BULLET_SCHED_STATS_EN
        check("shots0", 32'(shots0), 32'(m_shots[0]));
        check("shots1", 32'(shots1), 32'(m_shots[1]));
        check("dropped0", 32'(dropped0), 32'(m_drop[0]));
        check("dropped1", 32'(dropped1), 32'(m_drop[1]));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
